// File: rtl/seg_math_pipe.sv
// rtl/seg_math_pipe.sv - three-stage balance/steer speed math pipeline
//
// Purpose: turns a balance controller output plus a steering pot reading into
// left/right signed motor speed commands. Stage 1 applies the soft-start
// scaling and the steering offset, stage 2 mixes torques and applies deadzone
// shaping, stage 3 saturates to the output width and flags overspeed.
//
// Ports:
//   clk                 - only clock
//   rst                 - asynchronous active-high reset
//   vld_in              - sample strobe for PID_cntrl/steer_pot/en_steer/pwr_up
//   PID_cntrl[SPD_W]    - signed balance controller output
//   steer_pot[12]       - unsigned steering potentiometer reading
//   en_steer, pwr_up    - steering enable, motor power enable
//   vld_out             - one-cycle pulse when new speeds are presented
//   lft_spd, rght_spd   - signed motor speed commands, held between pulses
//   too_fast            - either speed above TOO_FAST_THR
//   ss_done             - soft-start timer saturated
//
// Optional feature: define SEG_MATH_SLEW_LIMIT_EN to rate-limit each output to
// SLEW_STEP per vld_out; a sample with pwr_up=0 still forces 0 immediately.

module seg_math_pipe #(
    parameter int SPD_W           = 12,
    parameter int SS_W            = 8,
    parameter int MIN_DUTY        = 168,
    parameter int LOW_TORQUE_BAND = 42,
    parameter int GAIN_MULT       = 4,
    parameter int TOO_FAST_THR    = 1536,
    parameter int SLEW_STEP       = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld_in,
    input  logic signed [SPD_W-1:0] PID_cntrl,
    input  logic        [11:0]      steer_pot,
    input  logic                    en_steer,
    input  logic                    pwr_up,
    output logic                    vld_out,
    output logic signed [SPD_W-1:0] lft_spd,
    output logic signed [SPD_W-1:0] rght_spd,
    output logic                    too_fast,
    output logic                    ss_done
);

    // Shaped torques carry two guard bits so +MIN_DUTY cannot wrap before
    // the saturation stage sees it.
    localparam int XW = SPD_W + 3;
    localparam int PW = SS_W + SPD_W + 1;

    localparam logic signed [XW-1:0]    BAND_X = XW'(LOW_TORQUE_BAND);
    localparam logic signed [XW-1:0]    DUTY_X = XW'(MIN_DUTY);
    localparam logic signed [XW-1:0]    GAIN_X = XW'(GAIN_MULT);
    localparam logic signed [SPD_W-1:0] MAX_V  = {1'b0, {(SPD_W-1){1'b1}}};
    localparam logic signed [SPD_W-1:0] MIN_V  = {1'b1, {(SPD_W-1){1'b0}}};
    localparam logic signed [XW-1:0]    MAX_X  = XW'(MAX_V);
    localparam logic signed [XW-1:0]    MIN_X  = XW'(MIN_V);
    localparam logic signed [SPD_W-1:0] THR_V  = SPD_W'(TOO_FAST_THR);

`ifdef SEG_MATH_SLEW_LIMIT_EN
    localparam logic signed [SPD_W:0]   STEP_D = (SPD_W+1)'(SLEW_STEP);
    localparam logic signed [SPD_W-1:0] STEP_W = SPD_W'(SLEW_STEP);
`else
    localparam int UNUSED_SLEW = SLEW_STEP;
`endif

    // Deadzone shaping: large torques get a duty offset to overcome motor
    // stiction, small ones are boosted linearly so the response stays smooth.
    function automatic logic signed [XW-1:0] shape(input logic signed [SPD_W:0] t,
                                                    input logic pwr);
        logic signed [XW-1:0] tx;
        tx = XW'(t);
        if (!pwr)
            shape = '0;
        else if (tx > BAND_X)
            shape = tx + DUTY_X;
        else if (tx < -BAND_X)
            shape = tx - DUTY_X;
        else
            shape = tx * GAIN_X;
    endfunction

    function automatic logic signed [SPD_W-1:0] sat(input logic signed [XW-1:0] s);
        if (s > MAX_X)
            sat = MAX_V;
        else if (s < MIN_X)
            sat = MIN_V;
        else
            sat = SPD_W'(s);
    endfunction

`ifdef SEG_MATH_SLEW_LIMIT_EN
    function automatic logic signed [SPD_W-1:0] slew(input logic signed [SPD_W-1:0] cur,
                                                      input logic signed [SPD_W-1:0] tgt);
        logic signed [SPD_W:0] diff;
        diff = (SPD_W+1)'(tgt) - (SPD_W+1)'(cur);
        // A step is only taken when the target lies beyond it, so cur+-step
        // always stays inside the output range.
        if (diff > STEP_D)
            slew = cur + STEP_W;
        else if (diff < -STEP_D)
            slew = cur - STEP_W;
        else
            slew = tgt;
    endfunction
`endif

    // Soft-start timer
    logic [SS_W-1:0] ss_tmr_q, ss_tmr_d;

    // Stage 1
    logic                    v1_q, v1_d;
    logic                    pwr1_q, pwr1_d;
    logic                    en1_q, en1_d;
    logic signed [SPD_W-1:0] pid_ss_q, pid_ss_d;
    logic signed [SPD_W:0]   steer_q, steer_d;

    // Stage 2
    logic                    v2_q, v2_d;
    logic signed [XW-1:0]    lft_sh_q, lft_sh_d;
    logic signed [XW-1:0]    rght_sh_q, rght_sh_d;
`ifdef SEG_MATH_SLEW_LIMIT_EN
    logic                    pwr2_q, pwr2_d;
`endif

    // Stage 3 / outputs
    logic                    vld_out_q, vld_out_d;
    logic signed [SPD_W-1:0] lft_q, lft_d;
    logic signed [SPD_W-1:0] rght_q, rght_d;
    logic                    too_fast_q, too_fast_d;

    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    ss_x;
    logic signed [PW-1:0]    pid_x;
    logic        [11:0]      pot_c;
    logic signed [12:0]      off;
    logic signed [12:0]      scaled;
    logic signed [SPD_W:0]   pid_w;
    logic signed [SPD_W:0]   lft_t;
    logic signed [SPD_W:0]   rght_t;
    logic signed [SPD_W-1:0] lft_tgt;
    logic signed [SPD_W-1:0] rght_tgt;
    logic                    unused_prod_bits;

    always_comb begin
        ss_tmr_d = ss_tmr_q;
        if (!pwr_up)
            ss_tmr_d = '0;
        else if (vld_in && (ss_tmr_q != {SS_W{1'b1}}))
            ss_tmr_d = ss_tmr_q + 1'b1;
    end

    // Stage 1: soft-start scaling uses the timer value before this sample's
    // increment; the >>> SS_W plus truncation is a plain bit slice.
    always_comb begin
        ss_x     = PW'($signed({1'b0, ss_tmr_q}));
        pid_x    = PW'(PID_cntrl);
        prod     = ss_x * pid_x;

        pot_c    = steer_pot;
        if (steer_pot < 12'h200)
            pot_c = 12'h200;
        else if (steer_pot > 12'hE00)
            pot_c = 12'hE00;
        off      = $signed({1'b0, pot_c}) - 13'sh7FF;
        scaled   = (off >>> 3) + (off >>> 4);

        v1_d     = vld_in;
        pwr1_d   = pwr1_q;
        en1_d    = en1_q;
        pid_ss_d = pid_ss_q;
        steer_d  = steer_q;
        if (vld_in) begin
            pwr1_d   = pwr_up;
            en1_d    = en_steer;
            pid_ss_d = prod[SS_W+SPD_W-1:SS_W];
            steer_d  = (SPD_W+1)'(scaled);
        end
    end

    assign unused_prod_bits = ^{prod[PW-1], prod[SS_W-1:0]};

    // Stage 2: torque mix and deadzone shaping
    always_comb begin
        pid_w     = (SPD_W+1)'(pid_ss_q);
        lft_t     = en1_q ? (pid_w + steer_q) : pid_w;
        rght_t    = en1_q ? (pid_w - steer_q) : pid_w;

        v2_d      = v1_q;
        lft_sh_d  = lft_sh_q;
        rght_sh_d = rght_sh_q;
`ifdef SEG_MATH_SLEW_LIMIT_EN
        pwr2_d    = pwr2_q;
`endif
        if (v1_q) begin
            lft_sh_d  = shape(lft_t, pwr1_q);
            rght_sh_d = shape(rght_t, pwr1_q);
`ifdef SEG_MATH_SLEW_LIMIT_EN
            pwr2_d    = pwr1_q;
`endif
        end
    end

    // Stage 3: saturate, optional slew limit, overspeed from final outputs
    always_comb begin
        lft_tgt    = sat(lft_sh_q);
        rght_tgt   = sat(rght_sh_q);

        vld_out_d  = v2_q;
        lft_d      = lft_q;
        rght_d     = rght_q;
        too_fast_d = too_fast_q;
        if (v2_q) begin
`ifdef SEG_MATH_SLEW_LIMIT_EN
            if (!pwr2_q) begin
                lft_d  = '0;
                rght_d = '0;
            end else begin
                lft_d  = slew(lft_q, lft_tgt);
                rght_d = slew(rght_q, rght_tgt);
            end
`else
            lft_d  = lft_tgt;
            rght_d = rght_tgt;
`endif
            too_fast_d = (lft_d > THR_V) || (rght_d > THR_V);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_tmr_q   <= '0;
            v1_q       <= 1'b0;
            pwr1_q     <= 1'b0;
            en1_q      <= 1'b0;
            pid_ss_q   <= '0;
            steer_q    <= '0;
            v2_q       <= 1'b0;
            lft_sh_q   <= '0;
            rght_sh_q  <= '0;
`ifdef SEG_MATH_SLEW_LIMIT_EN
            pwr2_q     <= 1'b0;
`endif
            vld_out_q  <= 1'b0;
            lft_q      <= '0;
            rght_q     <= '0;
            too_fast_q <= 1'b0;
        end else begin
            ss_tmr_q   <= ss_tmr_d;
            v1_q       <= v1_d;
            pwr1_q     <= pwr1_d;
            en1_q      <= en1_d;
            pid_ss_q   <= pid_ss_d;
            steer_q    <= steer_d;
            v2_q       <= v2_d;
            lft_sh_q   <= lft_sh_d;
            rght_sh_q  <= rght_sh_d;
`ifdef SEG_MATH_SLEW_LIMIT_EN
            pwr2_q     <= pwr2_d;
`endif
            vld_out_q  <= vld_out_d;
            lft_q      <= lft_d;
            rght_q     <= rght_d;
            too_fast_q <= too_fast_d;
        end
    end

    assign vld_out  = vld_out_q;
    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;
    assign too_fast = too_fast_q;
    assign ss_done  = (ss_tmr_q == {SS_W{1'b1}});

endmodule

// File: tb/tb_seg_math_pipe.sv
// tb/tb_seg_math_pipe.sv - scoreboard bench for seg_math_pipe with arithmetic reference model

module tb_seg_math_pipe;

    logic               clk = 1'b0;
    logic               rst;
    logic               vld_in;
    logic signed [11:0] PID_cntrl;
    logic        [11:0] steer_pot;
    logic               en_steer;
    logic               pwr_up;
    logic               vld_out;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               too_fast;
    logic               ss_done;

    seg_math_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .vld_in   (vld_in),
        .PID_cntrl(PID_cntrl),
        .steer_pot(steer_pot),
        .en_steer (en_steer),
        .pwr_up   (pwr_up),
        .vld_out  (vld_out),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .too_fast (too_fast),
        .ss_done  (ss_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int l;
        int r;
        bit tf;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   model_ss = 0;
    int   last_l = 0;
    int   last_r = 0;
    bit   last_tf = 1'b0;
    int   cur_l = 0;
    int   cur_r = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sat12(input int x);
        if (x > 2047) return 2047;
        if (x < -2048) return -2048;
        return x;
    endfunction

    function automatic int shape_m(input int t, input bit pwr);
        if (!pwr) return 0;
        if (t > 42) return t + 168;
        if (t < -42) return t - 168;
        return t * 4;
    endfunction

    function automatic int slew_m(input int cur, input int tgt);
        if (tgt - cur > 64) return cur + 64;
        if (tgt - cur < -64) return cur - 64;
        return tgt;
    endfunction

    // Drive one cycle; for a valid sample push its expected response.
    task automatic send(input bit v, input int pid, input int pot, input bit en,
                        input bit pwr, input bit dir, input int el, input int er,
                        input bit etf);
        int   ps, p, off, st, tl, tr, l, r;
        exp_t e;
        vld_in    = v;
        PID_cntrl = 12'(pid);
        steer_pot = 12'(pot);
        en_steer  = en;
        pwr_up    = pwr;
        if (v) begin
            ps  = (model_ss * pid) >>> 8;
            p   = (pot < 512) ? 512 : ((pot > 3584) ? 3584 : pot);
            off = p - 2047;
            st  = (off >>> 3) + (off >>> 4);
            tl  = en ? ps + st : ps;
            tr  = en ? ps - st : ps;
            l   = sat12(shape_m(tl, pwr));
            r   = sat12(shape_m(tr, pwr));
`ifdef SEG_MATH_SLEW_LIMIT_EN
            cur_l = pwr ? slew_m(cur_l, l) : 0;
            cur_r = pwr ? slew_m(cur_r, r) : 0;
            l = cur_l;
            r = cur_r;
            dir = 1'b0;
`endif
            if (dir) begin
                e.l  = el;
                e.r  = er;
                e.tf = etf;
            end else begin
                e.l  = l;
                e.r  = r;
                e.tf = (l > 1536) || (r > 1536);
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (!pwr) model_ss = 0;
        else if (v && model_ss < 255) model_ss++;
        #1;
        check("ss_done", int'(ss_done), int'(model_ss == 255));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 0, 12'h800, 1'b0, pwr_up, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: pops on every vld_out, otherwise checks outputs are held.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (vld_out) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_vld_out: got 1, expected 0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("lft_spd", int'(lft_spd), e.l);
                    check("rght_spd", int'(rght_spd), e.r);
                    check("too_fast", int'(too_fast), int'(e.tf));
                    last_l  = e.l;
                    last_r  = e.r;
                    last_tf = e.tf;
                end
            end else begin
                check("hold_lft", int'(lft_spd), last_l);
                check("hold_rght", int'(rght_spd), last_r);
                check("hold_too_fast", int'(too_fast), int'(last_tf));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        vld_in    = 1'b0;
        PID_cntrl = '0;
        steer_pot = 12'h800;
        en_steer  = 1'b0;
        pwr_up    = 1'b0;
        #12;
        check("rst_lft", int'(lft_spd), 0);
        check("rst_rght", int'(rght_spd), 0);
        check("rst_vld_out", int'(vld_out), 0);
        check("rst_too_fast", int'(too_fast), 0);
        check("rst_ss_done", int'(ss_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized mix of samples, bubbles and power drops
        for (int i = 0; i < 400; i++) begin
            send(($urandom_range(0, 9) < 7), int'($urandom_range(0, 4095)) - 2048,
                 int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 29) != 0), 1'b0, 0, 0, 1'b0);
        end
        drain();

        // Soft start from a cleared timer
        send(1'b0, 0, 12'h800, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            send(1'b1, 256, 12'h800, 1'b0, 1'b1, (i == 0) || (i == 255),
                 (i == 0) ? 0 : 423, (i == 0) ? 0 : 423, 1'b0);
        end
        check("ss_done_after_soft_start", int'(ss_done), 1);

        // Low torque band, steering and saturation with the timer saturated
        send(1'b1, 40, 12'h800, 1'b0, 1'b1, 1'b1, 156, 156, 1'b0);
        send(1'b1, -40, 12'h800, 1'b0, 1'b1, 1'b1, -160, -160, 1'b0);
        send(1'b1, 0, 12'hFFF, 1'b1, 1'b1, 1'b1, 456, -456, 1'b0);
        send(1'b1, 2047, 12'hFFF, 1'b1, 1'b1, 1'b1, 2047, 1919, 1'b1);
        send(1'b1, 2047, 12'h000, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        send(1'b1, -2048, 12'hFFF, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        send(1'b1, 2047, 12'hFFF, 1'b1, 1'b1, 1'b1, 2047, 1919, 1'b1);
        drain();

        // Reset mid-stream: two samples in flight plus one on the inputs
        send(1'b1, 100, 12'h900, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        send(1'b1, 200, 12'h700, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        vld_in    = 1'b1;
        PID_cntrl = 12'sd300;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_lft", int'(lft_spd), 0);
        check("midrst_rght", int'(rght_spd), 0);
        check("midrst_too_fast", int'(too_fast), 0);
        check("midrst_vld_out", int'(vld_out), 0);
        check("midrst_ss_done", int'(ss_done), 0);
        exp_q.delete();
        model_ss = 0;
        last_l   = 0;
        last_r   = 0;
        last_tf  = 1'b0;
        cur_l    = 0;
        cur_r    = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        vld_in = 1'b0;
        rst    = 1'b0;
        idle(6);

        // Life after reset: timer restarts from zero
        for (int i = 0; i < 20; i++) begin
            send(1'b1, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)),
                 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
